// File: rtl/byte_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// byte_serial_adder_pkg
// Shared definitions for the byte-serial adder controller and its adder slice.
//   BYTE_W  : width of one arithmetic slice (bits)
//   state_t : controller FSM encoding (2'd3 is unused and recovers to IDLE)
// -----------------------------------------------------------------------------
package byte_serial_adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_add8.sv
// -----------------------------------------------------------------------------
// byte_add8
// Combinational 8-bit adder slice producing a 9-bit result {cout, sum}.
// Ports:
//   din_a, din_b : byte operands
//   cin          : carry in
//   sum          : low byte of din_a + din_b + cin
//   cout         : carry out of the byte
// -----------------------------------------------------------------------------
module byte_add8
    import byte_serial_adder_pkg::*;
(
    input  logic [BYTE_W-1:0] din_a,
    input  logic [BYTE_W-1:0] din_b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] result;

    assign result = {1'b0, din_a} + {1'b0, din_b} + {{BYTE_W{1'b0}}, cin};
    assign sum    = result[BYTE_W-1:0];
    assign cout   = result[BYTE_W];

endmodule

// File: rtl/byte_serial_adder.sv
// -----------------------------------------------------------------------------
// byte_serial_adder
// Computes an (8*NUM_BYTES)-bit sum A+B+cin one byte per clock through a single
// byte_add8 slice; the inter-byte carry is held in a register between cycles.
// Ports:
//   clk, rst             : clock and synchronous active-high reset
//   in_valid / in_ready  : operand handshake (din_a, din_b, cin captured on accept)
//   out_valid / out_ready: result handshake (sum, cout held while out_valid)
//   sum, cout            : registered result and carry out of the top byte
//   busy                 : high while an operation is in CALC or DONE
// -----------------------------------------------------------------------------
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0] din_a,
    input  logic [BYTE_W*NUM_BYTES-1:0] din_b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BYTE_W*NUM_BYTES-1:0] sum,
    output logic                      cout,
    output logic                      busy
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic [W-1:0]       op_a_reg;
    logic [W-1:0]       op_b_reg;
    logic [W-1:0]       res_reg;
    logic               cout_reg;

    logic [BYTE_W-1:0]  slice_sum;
    logic               slice_cout;
    logic [W-1:0]       res_shift;
    logic               last_byte;
    logic               accept;

    // Low bytes of the operand shift registers always feed the slice.
    byte_add8 u_slice (
        .din_a (op_a_reg[BYTE_W-1:0]),
        .din_b (op_b_reg[BYTE_W-1:0]),
        .cin   (carry_reg),
        .sum   (slice_sum),
        .cout  (slice_cout)
    );

    // Result register shifts right by one byte; the new slice byte enters at
    // the top, so after NUM_BYTES shifts byte 0 has reached the bottom.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_res_shift
            if (gi == NUM_BYTES - 1) begin : g_top
                assign res_shift[gi*BYTE_W +: BYTE_W] = slice_sum;
            end else begin : g_low
                assign res_shift[gi*BYTE_W +: BYTE_W] = res_reg[(gi+1)*BYTE_W +: BYTE_W];
            end
        end
    endgenerate

    assign last_byte = (cnt_reg == CNT_W'(NUM_BYTES - 1));
    assign accept    = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (last_byte) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
        busy      = (state_reg == CALC) || (state_reg == DONE);
    end

    // Datapath: operand capture, byte-serial shift and carry chaining
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            res_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_a_reg  <= din_a;
                        op_b_reg  <= din_b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                    end
                end
                CALC: begin
                    op_a_reg  <= op_a_reg >> BYTE_W;
                    op_b_reg  <= op_b_reg >> BYTE_W;
                    res_reg   <= res_shift;
                    carry_reg <= slice_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_byte) begin
                        cout_reg <= slice_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = res_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_byte_serial_adder.sv
module tb_byte_serial_adder;

    logic        clk;
    logic        rst;

    // NUM_BYTES = 4 instance
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [31:0] din_a, din_b, sum;

    // NUM_BYTES = 1 instance
    logic        s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout, s_busy;
    logic [7:0]  s_din_a, s_din_b, s_sum;

    int checks = 0;
    int errors = 0;

    byte_serial_adder #(.NUM_BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .din_a(din_a), .din_b(din_b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    byte_serial_adder #(.NUM_BYTES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .din_a(s_din_a), .din_b(s_din_b), .cin(s_cin),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs are driven and outputs
    // sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid of the 4-byte instance rises (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; out_ready = 0; din_a = 0; din_b = 0; cin = 0;
        s_in_valid = 0; s_out_ready = 0; s_din_a = 0; s_din_b = 0; s_cin = 0;
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
        end
        checks++;
        if (sum !== 32'h0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data sum=%h cout=%b required 00000000/0", sum, cout);
        end
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_sum !== 8'h0 || s_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_n1 out_valid=%b in_ready=%b sum=%h cout=%b required 0/1/00/0", s_out_valid, s_in_ready, s_sum, s_cout);
        end
        rst = 1'b0;
        $display("reset: out_valid=%b in_ready=%b busy=%b sum=%h", out_valid, in_ready, busy, sum);
    endtask

    task automatic test_carry_byte();
        int n;
        din_a = 32'h000000FF; din_b = 32'h00000001; cin = 0;
        out_ready = 1; in_valid = 1;
        cycle();
        in_valid = 0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL carry_byte_busy busy=%b in_ready=%b required 1/0", busy, in_ready);
        end
        wait_valid(n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL carry_byte_latency edges=%0d required 4", n);
        end
        checks++;
        if (sum !== 32'h00000100 || cout !== 1'b0) begin
            errors++;
            $display("FAIL carry_byte_result sum=%h cout=%b required 00000100/0", sum, cout);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL carry_byte_pulse out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        $display("op A=000000ff B=00000001 cin=0 -> sum=%h cout=%b", sum, cout);
    endtask

    task automatic test_ripple();
        int n;
        din_a = 32'hFFFFFFFF; din_b = 32'h00000000; cin = 1;
        out_ready = 1; in_valid = 1;
        cycle();
        in_valid = 0;
        wait_valid(n);
        checks++;
        if (sum !== 32'h00000000 || cout !== 1'b1 || n !== 4) begin
            errors++;
            $display("FAIL ripple sum=%h cout=%b edges=%0d required 00000000/1/4", sum, cout, n);
        end
        cycle();
        $display("op A=ffffffff B=00000000 cin=1 -> sum=%h cout=%b", sum, cout);
    endtask

    task automatic test_backpressure();
        int n;
        din_a = 32'h80000000; din_b = 32'h80000000; cin = 0;
        out_ready = 0; in_valid = 1;
        cycle();
        din_a = 32'h11111111; din_b = 32'h22222222; cin = 1;
        wait_valid(n);
        checks++;
        if (n !== 4 || sum !== 32'h0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL bp_result sum=%h cout=%b edges=%0d required 00000000/1/4", sum, cout, n);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h0 || cout !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] out_valid=%b in_ready=%b sum=%h cout=%b required 1/0/00000000/1",
                         i, out_valid, in_ready, sum, cout);
            end
        end
        in_valid = 0;
        out_ready = 1;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
        end
        checks++;
        if (sum !== 32'h0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle_hold sum=%h cout=%b required 00000000/1", sum, cout);
        end
        $display("op A=80000000 B=80000000 cin=0 (stalled 5) -> sum=%h cout=%b", sum, cout);
    endtask

    task automatic test_mid_reset();
        int n;
        din_a = 32'hAAAAAAAA; din_b = 32'h55555555; cin = 1;
        out_ready = 1; in_valid = 1;
        cycle();
        in_valid = 0;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state out_valid=%b in_ready=%b sum=%h busy=%b required 0/1/00000000/0",
                     out_valid, in_ready, sum, busy);
        end
        din_a = 32'h12345678; din_b = 32'h11111111; cin = 0;
        in_valid = 1;
        cycle();
        in_valid = 0;
        wait_valid(n);
        checks++;
        if (sum !== 32'h23456789 || cout !== 1'b0 || n !== 4) begin
            errors++;
            $display("FAIL midrst_after sum=%h cout=%b edges=%0d required 23456789/0/4", sum, cout, n);
        end
        cycle();
        $display("op A=12345678 B=11111111 cin=0 after reset -> sum=%h cout=%b", sum, cout);
    endtask

    task automatic test_back_to_back();
        int n;
        din_a = 32'h01020304; din_b = 32'h10203040; cin = 0;
        out_ready = 1; in_valid = 1;
        cycle();
        // Second pair queued while the first is computing; must not disturb it.
        din_a = 32'hFFFF0000; din_b = 32'h00010000; cin = 1;
        wait_valid(n);
        checks++;
        if (sum !== 32'h11223344 || cout !== 1'b0 || n !== 4) begin
            errors++;
            $display("FAIL b2b_first sum=%h cout=%b edges=%0d required 11223344/0/4", sum, cout, n);
        end
        $display("op A=01020304 B=10203040 cin=0 -> sum=%h cout=%b", sum, cout);
        cycle();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        cycle();
        in_valid = 0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b in_ready=%b required 1/0", busy, in_ready);
        end
        wait_valid(n);
        checks++;
        if (sum !== 32'h00000001 || cout !== 1'b1 || n !== 4) begin
            errors++;
            $display("FAIL b2b_second sum=%h cout=%b edges=%0d required 00000001/1/4", sum, cout, n);
        end
        cycle();
        $display("op A=ffff0000 B=00010000 cin=1 -> sum=%h cout=%b", sum, cout);
    endtask

    task automatic test_random_n4();
        int n, k;
        logic [31:0] a, b;
        logic        c, hs;
        logic [32:0] expv;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
            expv = {1'b0, a} + {1'b0, b} + {32'b0, c};
            din_a = a; din_b = b; cin = c; in_valid = 1;
            out_ready = 1'($urandom_range(0, 1));
            cycle();
            in_valid = 0;
            wait_valid(n);
            checks++;
            if ({cout, sum} !== expv || n !== 4) begin
                errors++;
                $display("FAIL rand4[%0d] A=%h B=%h cin=%b got %b_%h edges=%0d required %b_%h edges=4",
                         i, a, b, c, cout, sum, n, expv[32], expv[31:0]);
            end
            $display("rand4 %0d A=%h B=%h cin=%b -> cout=%b sum=%h", i, a, b, c, cout, sum);
            hs = 0; k = 0;
            while (!hs && k < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                hs = out_ready;
                cycle();
                k++;
                if (!hs) begin
                    checks++;
                    if (out_valid !== 1'b1 || {cout, sum} !== expv) begin
                        errors++;
                        $display("FAIL rand4_stall[%0d] out_valid=%b result=%b_%h required 1/%b_%h",
                                 i, out_valid, cout, sum, expv[32], expv[31:0]);
                    end
                end
            end
        end
        out_ready = 0;
    endtask

    task automatic test_random_n1();
        int n, k;
        logic [7:0] a, b;
        logic       c, hs;
        logic [8:0] expv;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom_range(0, 1));
            expv = {1'b0, a} + {1'b0, b} + {8'b0, c};
            s_din_a = a; s_din_b = b; s_cin = c; s_in_valid = 1;
            s_out_ready = 1'($urandom_range(0, 1));
            cycle();
            s_in_valid = 0;
            n = 0;
            while (s_out_valid !== 1'b1 && n < 20) begin
                cycle();
                n++;
            end
            checks++;
            if ({s_cout, s_sum} !== expv || n !== 1) begin
                errors++;
                $display("FAIL rand1[%0d] A=%h B=%h cin=%b got %b_%h edges=%0d required %b_%h edges=1",
                         i, a, b, c, s_cout, s_sum, n, expv[8], expv[7:0]);
            end
            $display("rand1 %0d A=%h B=%h cin=%b -> cout=%b sum=%h", i, a, b, c, s_cout, s_sum);
            hs = 0; k = 0;
            while (!hs && k < 100) begin
                s_out_ready = 1'($urandom_range(0, 1));
                hs = s_out_ready;
                cycle();
                k++;
                if (!hs) begin
                    checks++;
                    if (s_out_valid !== 1'b1 || {s_cout, s_sum} !== expv) begin
                        errors++;
                        $display("FAIL rand1_stall[%0d] out_valid=%b result=%b_%h required 1/%b_%h",
                                 i, s_out_valid, s_cout, s_sum, expv[8], expv[7:0]);
                    end
                end
            end
        end
        s_out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_carry_byte();
        test_ripple();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random_n4();
        test_random_n1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
